ut_mul_gen: RTL and testbench
=============================

Name: ut_mul_gen

Overview:
- Parametrised successor of the accumulator processing unit: operand register R1, ALU, accumulator, carry register, now WIDTH-generic.
- Adds an iterative shift-add multiply with a busy/done handshake and a zero flag.
- Sits between data memory (data_in) and the sequencing controller, which drives the load strobes and sel_UAL and now observes busy/done.

Parameters:
WIDTH, 16, datapath width in bits; legal range 4..32.
MUL_EN, 1, 1: op 7 is the multi-cycle multiply; 0: op 7 is a single-cycle "pass R1" and busy/done stay 0.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  asynchronous reset, active-low (0 = reset).
ce  in  1  clock enable; when 0, all state (registers and FSM) holds.
sel_UAL  in  3  ALU operation select.
data_in  in  WIDTH  operand from memory into R1.
data_out  out  WIDTH  accumulator contents.
load_R1  in  1  R1 <= data_in.
load_accu  in  1  ACCU <= ALU result; for MUL, launches the multiply.
load_carry  in  1  carry <= ALU carry-out.
init_carry  in  1  carry <= 0; takes priority over load_carry.
carry  out  1  carry register.
zero  out  1  combinational, 1 when ACCU == 0.
busy  out  1  multiply in progress.
done  out  1  one-cycle pulse on the multiply completion edge.

Behaviour:
- Reset (rst=0, asynchronous): R1=0, ACCU=0, carry=0, FSM=IDLE, busy=0, done=0, so zero=1. Reset mid-multiply aborts it, with no done pulse.
- Every state change also requires ce=1. When ce=0, FSM, counters and the done pulse all freeze (done holds its value).
- ALU, combinational on R1 and ACCU, carry-out c:
  - 0 NOR: result ~(ACCU|R1), c=0.
  - 1 ADD: ACCU+R1, c = bit WIDTH of the sum.
  - 2 ADC: ACCU+R1+carry, c = bit WIDTH of the sum.
  - 3 SUB: ACCU-R1, c=1 when ACCU>=R1 (no borrow).
  - 4 AND: c=0.
  - 5 XOR: c=0.
  - 6 SHL: ACCU<<1, c=ACCU[WIDTH-1].
  - 7: MUL when MUL_EN=1; pass R1 with c=0 when MUL_EN=0.
- Single-cycle ops, in IDLE:
  - load_R1, load_accu and load_carry act independently on the same edge, using pre-edge R1/ACCU.
  - init_carry clears carry regardless of the other strobes.
- FSM states: IDLE, MUL_RUN.
  - IDLE -> MUL_RUN on an edge with load_accu=1, sel_UAL=7, MUL_EN=1.
  - That launch edge captures multiplicand=ACCU and multiplier=R1, clears the 2*WIDTH product register, and latches pend_carry = load_carry & ~init_carry.
  - init_carry on the launch edge still clears carry immediately.
  - load_R1 on the launch edge is honoured: R1 updates, and the multiply uses the old R1.
  - MUL_RUN: one shift-add iteration per enabled edge, WIDTH iterations. busy=1 throughout MUL_RUN, i.e. exactly WIDTH enabled cycles.
  - On the WIDTH-th iteration edge:
    - ACCU <= product[WIDTH-1:0].
    - If pend_carry, carry <= (product[2*WIDTH-1:WIDTH] != 0), the overflow flag.
    - done=1 for the following cycle; FSM returns to IDLE.
- While busy=1, load_R1, load_accu, load_carry and init_carry are ignored. R1 and carry are stable and ACCU shows its old value until completion.
- Back-to-back multiplies: a launch is accepted on the cycle in which done=1.
- Arithmetic is modulo 2^WIDTH. The product is unsigned.

Test Plan (WIDTH=16, MUL_EN=1):
1. Reset: assert rst=0 mid-run -> data_out=0x0000, carry=0, zero=1, busy=0, done=0 at once, without waiting for a clock.
2. ADD overflow: ACCU=0x0001, R1=0xFFFF, sel=1, load_accu+load_carry -> ACCU=0x0000, carry=1, zero=1. Then sel=2 with R1=0x0003 -> ACCU=0x0004, carry=0.
3. SUB and SHL:
   - ACCU=0x0003, R1=0x0005, sel=3 -> ACCU=0xFFFE, carry=0.
   - Then sel=6 -> ACCU=0xFFFC, carry=1.
   - init_carry together with load_carry -> carry=0.
4. Multiply:
   - ACCU=0x0123, R1=0x0045, sel=7, load_accu+load_carry -> busy=1 for 16 cycles, then ACCU=0x4E6F, carry=0, single done pulse.
   - 0x1000*0x0010 -> ACCU=0x0000, carry=1, zero=1.
5. Busy lockout: pulse load_R1 (data_in=0xAAAA), load_accu and init_carry during MUL_RUN -> R1, carry unchanged; result as in scenario 4. Drop ce for 3 cycles mid-run -> busy lasts 19 cycles, same result.
6. MUL_EN=0 build: sel=7, R1=0x5A5A, load_accu -> ACCU=0x5A5A after one edge, busy and done never assert.

Source files
------------

// File: rtl/ut_mul_gen.sv
// Accumulator processing unit: operand register R1, ALU, accumulator and carry,
// plus an iterative shift-add multiply (op 7) with a busy/done handshake.
module ut_mul_gen #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [2:0]       sel_UAL,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic             load_R1,
    input  logic             load_accu,
    input  logic             load_carry,
    input  logic             init_carry,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     r1;
    logic [WIDTH-1:0]     accu;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   product_next;
    logic [CNT_W-1:0]     cnt;
    logic                 carry_q;
    logic                 pend_carry;
    logic                 done_q;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic [WIDTH:0]       wide;
    logic                 launch;
    logic                 last_iter;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        case (sel_UAL)
            3'd0: alu_res = ~(accu | r1);
            3'd1: begin
                wide    = {1'b0, accu} + {1'b0, r1};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            3'd2: begin
                wide    = {1'b0, accu} + {1'b0, r1} + {{WIDTH{1'b0}}, carry_q};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            3'd3: begin
                // No borrow out of the top bit means ACCU >= R1.
                wide    = {1'b0, accu} - {1'b0, r1};
                alu_res = wide[WIDTH-1:0];
                alu_c   = ~wide[WIDTH];
            end
            3'd4: alu_res = accu & r1;
            3'd5: alu_res = accu ^ r1;
            3'd6: begin
                alu_res = {accu[WIDTH-2:0], 1'b0};
                alu_c   = accu[WIDTH-1];
            end
            default: alu_res = r1;
        endcase
    end

    assign launch       = (MUL_EN == 1'b1) && (state == IDLE) && load_accu && (sel_UAL == 3'd7);
    assign last_iter    = (cnt == CNT_W'(WIDTH - 1));
    assign product_next = mplier[0] ? (product + mcand) : product;

    // Control and architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            r1         <= '0;
            accu       <= '0;
            carry_q    <= 1'b0;
            pend_carry <= 1'b0;
            done_q     <= 1'b0;
            cnt        <= '0;
        end else if (ce) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_R1)
                        r1 <= data_in;
                    if (init_carry)
                        carry_q <= 1'b0;
                    else if (load_carry && !launch)
                        carry_q <= alu_c;
                    if (launch) begin
                        state      <= MUL_RUN;
                        pend_carry <= load_carry & ~init_carry;
                        cnt        <= '0;
                    end else if (load_accu) begin
                        accu <= alu_res;
                    end
                end
                MUL_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        accu <= product_next[WIDTH-1:0];
                        if (pend_carry)
                            carry_q <= |product_next[2*WIDTH-1:WIDTH];
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift-add datapath: one partial product per enabled MUL_RUN edge.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (launch) begin
                mcand   <= {{WIDTH{1'b0}}, accu};
                mplier  <= r1;
                product <= '0;
            end else if (state == MUL_RUN) begin
                product <= product_next;
                mcand   <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier  <= {1'b0, mplier[WIDTH-1:1]};
            end
        end
    end

    assign data_out = accu;
    assign carry    = carry_q;
    assign zero     = (accu == '0);
    assign busy     = (state == MUL_RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_ut_mul_gen.sv
// Bench for ut_mul_gen: directed scenarios plus randomized traffic against a
// transaction-level model (multiply as a single '*' with a cycle countdown).
module tb_ut_mul_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic [2:0]  sel = 3'd0;
    logic [15:0] din = 16'h0;
    logic        ld_r1 = 1'b0, ld_acc = 1'b0, ld_c = 1'b0, init_c = 1'b0;
    logic [15:0] dout, dout0;
    logic        carry_o, zero_o, busy_o, done_o;
    logic        carry0, zero0, busy0, done0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    ut_mul_gen #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .sel_UAL(sel), .data_in(din), .data_out(dout),
        .load_R1(ld_r1), .load_accu(ld_acc), .load_carry(ld_c), .init_carry(init_c),
        .carry(carry_o), .zero(zero_o), .busy(busy_o), .done(done_o));

    ut_mul_gen #(.WIDTH(16), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .sel_UAL(sel), .data_in(din), .data_out(dout0),
        .load_R1(ld_r1), .load_accu(ld_acc), .load_carry(ld_c), .init_carry(init_c),
        .carry(carry0), .zero(zero0), .busy(busy0), .done(done0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    logic [15:0] m_r1 = 0, m_accu = 0;
    logic        m_carry = 0, m_done = 0, m_pend = 0;
    logic [31:0] m_prod = 0;
    int          m_left = 0;

    always @(posedge clk or negedge rst) begin
        int a, r, t, res;
        bit c, launch, done_n;
        if (!rst) begin
            m_r1 = 0; m_accu = 0; m_carry = 0; m_left = 0; m_done = 0;
        end else if (ce) begin
            done_n = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_accu = m_prod[15:0];
                    if (m_pend) m_carry = (m_prod >= 32'h10000);
                    done_n = 1;
                end
            end else begin
                a = int'(m_accu); r = int'(m_r1); c = 0; res = 0;
                case (sel)
                    3'd0: res = ~(a | r);
                    3'd1: begin t = a + r; res = t; c = (t > 65535); end
                    3'd2: begin t = a + r + int'(m_carry); res = t; c = (t > 65535); end
                    3'd3: begin res = a - r; c = (a >= r); end
                    3'd4: res = a & r;
                    3'd5: res = a ^ r;
                    3'd6: begin res = a * 2; c = (a >= 32768); end
                    default: res = r;
                endcase
                launch = ld_acc && (sel == 3'd7);
                if (launch) begin
                    m_prod = 32'(a) * 32'(r);
                    m_pend = ld_c && !init_c;
                    m_left = 16;
                end
                if (ld_r1) m_r1 = din;
                if (ld_acc && !launch) m_accu = res[15:0];
                if (init_c) m_carry = 0;
                else if (ld_c && !launch) m_carry = c;
            end
            m_done = done_n;
        end
    end

    always @(negedge clk) begin
        if (chk_on && rst) begin
            chk("data_out", 32'(dout), 32'(m_accu));
            chk("carry", 32'(carry_o), 32'(m_carry));
            chk("zero", 32'(zero_o), 32'(m_accu == 16'h0));
            chk("busy", 32'(busy_o), 32'(m_left > 0));
            chk("done", 32'(done_o), 32'(m_done));
            chk("busy_nomul", 32'(busy0), 32'(0));
            chk("done_nomul", 32'(done0), 32'(0));
        end
    end

    task automatic step(input logic lr1, input logic [15:0] d, input logic lacc,
                        input logic [2:0] s, input logic lc, input logic ic);
        @(negedge clk);
        ld_r1 = lr1; din = d; ld_acc = lacc; sel = s; ld_c = lc; init_c = ic;
        @(negedge clk);
        ld_r1 = 0; ld_acc = 0; ld_c = 0; init_c = 0;
    endtask

    task automatic load_r1(input logic [15:0] v);
        step(1, v, 0, 3'd0, 0, 0);
    endtask

    task automatic set_accu(input logic [15:0] v);
        load_r1(16'hFFFF);
        step(0, 0, 1, 3'd0, 0, 0);
        load_r1(v);
        step(0, 0, 1, 3'd1, 0, 0);
    endtask

    task automatic run_mul(input int ce_off_at, input bit poke, output int n);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            if (poke && n == 3) begin
                ld_r1 = 1; din = 16'hAAAA; ld_acc = 1; sel = 3'd1; init_c = 1;
            end
            if (poke && n == 4) begin
                ld_r1 = 0; ld_acc = 0; init_c = 0; sel = 3'd0;
                chk("lock_carry", 32'(carry_o), 32'(1));
                chk("lock_accu", 32'(dout), 32'(16'h0123));
            end
            if (n == ce_off_at) ce = 0;
            if (ce_off_at > 0 && n == ce_off_at + 3) ce = 1;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1;
        chk_on = 1;

        set_accu(16'h0001); load_r1(16'hFFFF);
        step(0, 0, 1, 3'd1, 1, 0);
        chk("add_accu", 32'(dout), 32'(16'h0000));
        chk("add_carry", 32'(carry_o), 32'(1));
        chk("add_zero", 32'(zero_o), 32'(1));
        load_r1(16'h0003);
        step(0, 0, 1, 3'd2, 1, 0);
        chk("adc_accu", 32'(dout), 32'(16'h0004));
        chk("adc_carry", 32'(carry_o), 32'(0));

        set_accu(16'h0003); load_r1(16'h0005);
        step(0, 0, 1, 3'd3, 1, 0);
        chk("sub_accu", 32'(dout), 32'(16'hFFFE));
        chk("sub_carry", 32'(carry_o), 32'(0));
        step(0, 0, 1, 3'd6, 1, 0);
        chk("shl_accu", 32'(dout), 32'(16'hFFFC));
        chk("shl_carry", 32'(carry_o), 32'(1));
        step(0, 0, 0, 3'd6, 1, 1);
        chk("init_carry", 32'(carry_o), 32'(0));

        set_accu(16'h0123); load_r1(16'h0045);
        step(0, 0, 1, 3'd7, 1, 0);
        run_mul(0, 0, n);
        chk("mul_busy_len", 32'(n), 32'(16));
        chk("mul_accu", 32'(dout), 32'(16'h4E6F));
        chk("mul_carry", 32'(carry_o), 32'(0));
        chk("mul_done", 32'(done_o), 32'(1));
        @(negedge clk);
        chk("mul_done_pulse", 32'(done_o), 32'(0));

        set_accu(16'h1000); load_r1(16'h0010);
        step(0, 0, 1, 3'd7, 1, 0);
        run_mul(0, 0, n);
        chk("ovf_accu", 32'(dout), 32'(16'h0000));
        chk("ovf_carry", 32'(carry_o), 32'(1));
        chk("ovf_zero", 32'(zero_o), 32'(1));

        set_accu(16'h0123); load_r1(16'h0045);
        step(0, 0, 1, 3'd7, 1, 0);
        run_mul(0, 1, n);
        chk("lock_busy_len", 32'(n), 32'(16));
        chk("lock_result", 32'(dout), 32'(16'h4E6F));
        chk("lock_carry_end", 32'(carry_o), 32'(0));
        step(0, 0, 1, 3'd1, 0, 0);
        chk("lock_r1_kept", 32'(dout), 32'(16'h4EB4));

        set_accu(16'h0123); load_r1(16'h0045);
        step(0, 0, 1, 3'd7, 1, 0);
        run_mul(5, 0, n);
        chk("ce_busy_len", 32'(n), 32'(19));
        chk("ce_result", 32'(dout), 32'(16'h4E6F));
        chk("ce_done", 32'(done_o), 32'(1));
        ce = 0;
        @(negedge clk);
        chk("ce_done_hold", 32'(done_o), 32'(1));
        ce = 1;
        @(negedge clk);
        chk("ce_done_clear", 32'(done_o), 32'(0));

        set_accu(16'h0001); load_r1(16'hFFFF);
        step(0, 0, 1, 3'd1, 1, 0);
        set_accu(16'h1234); load_r1(16'h0077);
        step(0, 0, 1, 3'd7, 1, 0);
        repeat (5) @(negedge clk);
        chk("pre_rst_carry", 32'(carry_o), 32'(1));
        #2 rst = 0;
        #1;
        chk("rst_accu", 32'(dout), 32'(16'h0000));
        chk("rst_carry", 32'(carry_o), 32'(0));
        chk("rst_zero", 32'(zero_o), 32'(1));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_no_done", 32'(done_o), 32'(0));
        end

        load_r1(16'h5A5A);
        step(0, 0, 1, 3'd7, 1, 0);
        chk("pass_accu", 32'(dout0), 32'(16'h5A5A));
        chk("pass_carry", 32'(carry0), 32'(0));
        chk("pass_zero", 32'(zero0), 32'(0));

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ce     = ($urandom_range(0, 7) != 0);
            ld_r1  = ($urandom_range(0, 2) == 0);
            din    = 16'($urandom);
            ld_acc = ($urandom_range(0, 2) == 0);
            sel    = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            ld_c   = ($urandom_range(0, 1) == 0);
            init_c = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        ce = 1; ld_r1 = 0; ld_acc = 0; ld_c = 0; init_c = 0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
